// File: rtl/uartprobe_pkg.sv
// Shared opcodes, response codes and controller state encoding for uartprobe.
package uartprobe_pkg;

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_ID    = 8'h03;

    localparam logic [7:0] RSP_ACK = 8'hAA;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RX_PAYLOAD = 2'd1,
        TX         = 2'd2
    } state_t;

endpackage

// File: rtl/uartprobe_byte_shifter.sv
// Byte-wide shift register: parallel load, shifts toward byte 0, fill byte enters at the top.
// Latency: load/shift visible the cycle after the enable edge; head is byte 0.
// Backpressure: none, the owner gates load_en/shift_en with its own handshakes.
module uartprobe_byte_shifter #(
    parameter int BYTES = 4
) (
    input  logic               clk,
    input  logic               aresetn,
    input  logic               load_en,
    input  logic [8*BYTES-1:0] load_dat,
    input  logic               shift_en,
    input  logic [7:0]         fill_byte,
    output logic [7:0]         head,
    output logic [8*BYTES-1:0] shift_dat
);

    logic [8*BYTES-1:0] q;

    generate
        if (BYTES == 1) begin : g_one
            assign shift_dat = fill_byte;
        end else begin : g_multi
            assign shift_dat = {fill_byte, q[8*BYTES-1:8]};
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_dat;
        end else if (shift_en) begin
            q <= shift_dat;
        end
    end

    assign head = q[7:0];

endmodule

// File: rtl/uartprobe_cmd_ctrl.sv
// Decodes rx command bytes, snapshots/updates probes, and streams response bytes on tx.
// Latency: first response byte valid one cycle after the accepting rx edge (or last payload byte).
// Backpressure: tx_valid holds until tx_ready; rx_ready is low for the whole response.
module uartprobe_cmd_ctrl
    import uartprobe_pkg::*;
#(
    parameter int                       PROBE_BYTES = 4,
    parameter logic [7:0]               ID_BYTE     = 8'h5A,
    parameter logic [8*PROBE_BYTES-1:0] OUT_RESET   = '0
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       rx_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    input  logic [8*PROBE_BYTES-1:0]   probe_in,
    output logic [8*PROBE_BYTES-1:0]   probe_out,
    output logic                       probe_out_strobe,
    output logic                       busy
);

    localparam int             PW       = 8 * PROBE_BYTES;
    localparam int             CW       = $clog2(PROBE_BYTES + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(PROBE_BYTES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            rx_hs, tx_hs, last, commit;
    logic            sh_load, sh_shift;
    logic [PW-1:0]   sh_load_dat, sh_shift_dat;
    logic [7:0]      sh_fill;

    assign rx_hs  = rx_valid && rx_ready;
    assign tx_hs  = tx_valid && tx_ready;
    assign last   = (cnt == CNT_ONE);
    assign commit = (state == RX_PAYLOAD) && rx_hs && last;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (rx_hs) state_nxt = (rx_data == CMD_WRITE) ? RX_PAYLOAD : TX;
            RX_PAYLOAD: if (rx_hs && last) state_nxt = TX;
            TX:         if (tx_hs && last) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (state == TX);
        busy     = (state != IDLE);
    end

    // One shifter serves both directions: payload enters at the top, responses leave from byte 0.
    always_comb begin
        sh_load     = 1'b0;
        sh_load_dat = '0;
        sh_shift    = 1'b0;
        sh_fill     = 8'h00;
        case (state)
            IDLE: begin
                if (rx_hs) begin
                    case (rx_data)
                        CMD_READ:  begin sh_load = 1'b1; sh_load_dat = probe_in;          end
                        CMD_WRITE: ;
                        CMD_ID:    begin sh_load = 1'b1; sh_load_dat = PW'(ID_BYTE);      end
                        default:   begin sh_load = 1'b1; sh_load_dat = PW'(RSP_NAK);      end
                    endcase
                end
            end
            RX_PAYLOAD: begin
                sh_fill = rx_data;
                if (rx_hs) begin
                    if (last) begin
                        sh_load     = 1'b1;
                        sh_load_dat = PW'(RSP_ACK);
                    end else begin
                        sh_shift = 1'b1;
                    end
                end
            end
            TX:      sh_shift = tx_hs;
            default: ;
        endcase
    end

    uartprobe_byte_shifter #(.BYTES(PROBE_BYTES)) u_shifter (
        .clk       (clk),
        .aresetn   (aresetn),
        .load_en   (sh_load),
        .load_dat  (sh_load_dat),
        .shift_en  (sh_shift),
        .fill_byte (sh_fill),
        .head      (tx_data),
        .shift_dat (sh_shift_dat)
    );

    // The full shadow including the final payload byte commits in one edge, so no partial update shows.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt              <= '0;
            probe_out        <= OUT_RESET;
            probe_out_strobe <= 1'b0;
            rx_ready         <= 1'b0;
        end else begin
            probe_out_strobe <= commit;
            rx_ready         <= (state_nxt != TX);
            if (commit) probe_out <= sh_shift_dat;
            case (state)
                IDLE: begin
                    if (rx_hs)
                        cnt <= (rx_data == CMD_READ || rx_data == CMD_WRITE) ? CNT_FULL : CNT_ONE;
                end
                RX_PAYLOAD: begin
                    if (rx_hs) cnt <= last ? CNT_ONE : cnt - CNT_ONE;
                end
                TX: begin
                    if (tx_hs) cnt <= cnt - CNT_ONE;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: doc/uartprobe_cmd_ctrl.md
Name: uartprobe_cmd_ctrl

Overview:
- Command controller that sequences the uartprobe UART wrapper's byte streams.
- Consumes command bytes from the wrapper's rx stream and decodes them.
- Snapshots probe inputs or updates probe outputs, then emits response bytes on the wrapper's tx stream.
- Sits between uartprobe_uartwrapper and the user probe signals; it is the only master of both streams.

Parameters:
- PROBE_BYTES, 4: width of probe_in / probe_out in bytes (1..16).
- ID_BYTE, 8'h5A: value returned by the ID command.
- OUT_RESET, 0: reset value of probe_out (8*PROBE_BYTES bits).

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- rx_valid  in  1  wrapper has a received byte.
- rx_data  in  8  received byte.
- rx_ready  out  1  controller accepts a byte this cycle.
- tx_valid  out  1  controller presents a byte to transmit.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  wrapper accepts the tx byte.
- probe_in  in  8*PROBE_BYTES  signals to observe (synchronous to clk).
- probe_out  out  8*PROBE_BYTES  driven probe signals.
- probe_out_strobe  out  1  one-cycle pulse when probe_out updates.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock is clk; reset is aresetn, asynchronous assert, active-low.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, probe_out=OUT_RESET, probe_out_strobe=0, busy=0, state=IDLE.
- First cycle after reset release: state is IDLE, rx_ready=1.
- Transfers occur only on valid&&ready. tx_valid, once high, stays high with tx_data stable until tx_ready.
- Commands:
  - 8'h01 READ: respond with a PROBE_BYTES-byte snapshot of probe_in, byte 0 (bits 7:0) first.
  - 8'h02 WRITE: followed by PROBE_BYTES payload bytes, byte 0 first; respond 8'hAA.
  - 8'h03 ID: respond ID_BYTE.
  - Any other value: respond 8'hEE (NAK).
- State IDLE: rx_ready=1, tx_valid=0. On an rx handshake:
  - READ: capture probe_in into the tx shift register in the same edge; count=PROBE_BYTES; go to TX.
  - WRITE: count=PROBE_BYTES; go to RX_PAYLOAD.
  - ID / unknown: load the single response byte; count=1; go to TX.
- State RX_PAYLOAD: rx_ready=1.
  - Each handshake writes the byte into the shadow register at index PROBE_BYTES-count and decrements count.
  - On the last byte: the next edge copies shadow into probe_out, pulses probe_out_strobe for exactly one cycle, loads 8'hAA with count=1, and goes to TX.
  - probe_out never shows a partial update.
- State TX: rx_ready=0, tx_valid=1, tx_data = current byte.
  - Each tx handshake shifts the next byte in and decrements count.
  - When count reaches 0, go to IDLE; tx_valid deasserts on the next cycle.
- Latency: tx_valid rises on the first cycle after the accepting rx edge (READ/ID/NAK) or after the last payload byte (WRITE).
- rx bytes arriving during TX are held off by rx_ready=0; none are dropped or merged.
- tx_ready asserted while tx_valid=0 has no effect.
- Count width is clog2(PROBE_BYTES+1). Byte index is zero-based; counters do not wrap.
- Reset mid-payload discards the shadow register and restores probe_out to OUT_RESET.
- Reset mid-TX drops tx_valid immediately (asynchronous).
- busy = (state != IDLE).

Decomposition:
- Package uartprobe_pkg holds:
  - Command opcodes: CMD_READ=8'h01, CMD_WRITE=8'h02, CMD_ID=8'h03.
  - Response codes: RSP_ACK=8'hAA, RSP_NAK=8'hEE.
  - State encoding: IDLE, RX_PAYLOAD, TX.
- Natural sub-module: uartprobe_byte_shifter, a PROBE_BYTES-deep byte shift register with parallel load and serial byte out. It is shared for the tx snapshot and the rx shadow assembly.

Test Plan:
- ID: rx 03 with tx_ready=1 -> tx emits 5A one cycle after the rx handshake; busy returns to 0 the cycle after the tx handshake.
- READ: probe_in=32'hDEADBEEF, rx 01, then change probe_in to 0 on the next cycle -> tx sequence EF BE AD DE (snapshot held); tx_ready toggled 1/0 each cycle, and tx_data is stable while stalled.
- WRITE: rx 02 11 22 33 44 -> probe_out=32'h44332211 with a single-cycle strobe after the 4th byte; probe_out unchanged before that; tx emits AA; rx_ready=0 while AA is pending.
- Unknown command: rx 7F -> tx EE; then rx 03 -> tx 5A (controller recovered).
- Backpressure: tx_ready held 0 for 20 cycles during READ while rx_valid=1 with byte 03 -> rx_ready stays 0, no byte lost; 03 is accepted after the READ completes and answered with 5A.
- Reset mid-op: aresetn low after rx 02 11 22 -> probe_out=OUT_RESET, tx_valid=0; after release, rx 03 -> 5A.
